pixie_dma_ctrl: RTL
===================

// Module: pixie_dma_ctrl
// PURPOSE
//  CDP1861 (Pixie) front end in the CDP1802 bus clock domain. Generates line/frame timing,
//  DMAO/INT/EFx to the CPU, and captures DMA-out bytes (SC=S2) into the 1 KB dual-port
//  frame buffer write port. The video back end reads that buffer in the video clock domain.
// PARAMETERS
//  CLKS_PER_MC      8    clk_enable pulses per 1802 machine cycle
//  MC_PER_LINE      14   machine cycles per scan line
//  LINES_PER_FRAME  262  scan lines per frame
//  FIRST_DISP_LINE  80   first displayed line; 128 display lines (80..207)
// PORTS
//  clk         in   1   CPU bus clock
//  reset       in   1   synchronous, active-high
//  clk_enable  in   1   CPU clock-enable; all state advances only when high
//  SC          in   2   1802 state code (2'b10 = S2 DMA)
//  disp_on     in   1   display enable strobe (INP 1)
//  disp_off    in   1   display disable strobe (OUT 1)
//  data_in     in   8   CPU data bus during S2
//  DMAO        out  1   DMA-out request, active-high
//  INT         out  1   interrupt request, active-high
//  EFx         out  1   frame-position flag, active-high
//  mem_addr    out  10  frame-buffer write address {line[6:0], byte[2:0]}
//  mem_data    out  8   frame-buffer write data
//  mem_wr_en   out  1   one-clk write strobe, coincides with a clk_enable pulse
//  dma_underrun out 1   (PIXIE_DMA_CHECK_EN only) sticky underrun flag
// BEHAVIOUR
//  - Reset: ph=0, mc=0, line=0, disp_en=0, byte_idx=0; all outputs 0, mem_addr=0, mem_data=0.
//    Reset mid-frame or mid-DMA abandons the line; no partial write follows.
//  - ph counts 0..CLKS_PER_MC-1 on clk_enable. On wrap, mc advances 0..13. On mc wrap, line
//    advances 0..261, then wraps to 0. There is no other way to restart the counters.
//  - disp_en: set by disp_on, cleared by disp_off, sampled on clk_enable.
//    Both high in the same cycle: disp_off wins.
//  - Display line: FIRST_DISP_LINE <= line <= FIRST_DISP_LINE+127.
//  - DMAO=1 when disp_en, display line and 1<=mc<=8. Registered; changes on the ph wrap.
//  - INT=1 when disp_en and line in {78,79}. Cleared at line 80 mc 0 regardless of CPU ack.
//  - EFx=1 when line in 76..79 or 204..207, independent of disp_en.
//  - Capture: on clk_enable with ph==CLKS_PER_MC-1, SC==2'b10, disp_en and a display line:
//      - mem_data<=data_in
//      - mem_addr<={line-80 [6:0], byte_idx}
//      - mem_wr_en pulses for 1 clk
//      - byte_idx++
//  - byte_idx resets to 0 at mc 0 of each line. S2 cycles beyond 8 in a line are ignored (no
//    write, no wrap onto the next row). S2 outside display lines or with disp_en=0 is ignored.
//  - disp_off mid-line: remaining DMAO cycles drop at the next ph wrap. Bytes already written
//    stay in the buffer.
//  - Latency: data_in to mem_wr_en is 1 clk.
// CONFIGURATION
//  PIXIE_DMA_CHECK_EN defined:
//   - At the last mc of each display line with disp_en, byte_idx<8 sets dma_underrun.
//   - dma_underrun clears on reset or disp_on.
//  Not defined: port dma_underrun is absent and no check logic is built.
// STRUCTURE
//  - pixie_pkg holds: SC_S2 code, MC_PER_LINE, LINES_PER_FRAME, display-line bounds,
//    INT lines (78/79) and EFx windows (76-79, 204-207).
//  - One sub-module, pixie_timing_gen: ph/mc/line counters plus decoded line/cycle flags.
//  - This module holds the display-enable latch, the DMA capture path and the output registers.
// TESTING
//  - Reset held 3 clks mid-line 100 -> all outputs 0; counters at line 0, mc 0.
//  - Free-run, disp_en=1:
//     - INT high exactly during lines 78-79.
//     - EFx high during lines 76-79 and 204-207.
//     - Frame period = 262*14*8 clk_enable pulses.
//  - disp_on, then 8 S2 cycles on line 80 with data 0x01..0x08 -> writes at addr 0..7 with
//    0x01..0x08. On line 207, byte 7 goes to addr 0x3FF.
//  - 10 S2 cycles on line 81 -> exactly 8 writes (addr 8..15); the 9th and 10th are dropped.
//  - disp_off and disp_on asserted together -> disp_en=0, no DMAO, no INT. EFx still toggles.
//  - PIXIE_DMA_CHECK_EN: only 5 S2 cycles on line 90 -> dma_underrun=1 after line 90 mc 13.
//    It stays set until disp_on.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared constants and position decode for the CDP1861 (Pixie) front end.
// Timing counts, display window, INT lines and EFx windows all live here.
package pixie_pkg;

  localparam int CLKS_PER_MC     = 8;
  localparam int MC_PER_LINE     = 14;
  localparam int LINES_PER_FRAME = 262;

  localparam int PH_W   = 3;
  localparam int MC_W   = 4;
  localparam int LINE_W = 9;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_MC - 1);
  localparam logic [MC_W-1:0]   MC_LAST   = MC_W'(MC_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

  localparam logic [1:0] SC_S2 = 2'b10;

  localparam logic [LINE_W-1:0] FIRST_DISP_LINE = 9'd80;
  localparam logic [LINE_W-1:0] LAST_DISP_LINE  = 9'd207;
  localparam logic [LINE_W-1:0] INT_LINE_0      = 9'd78;
  localparam logic [LINE_W-1:0] INT_LINE_1      = 9'd79;
  localparam logic [LINE_W-1:0] EF_TOP_LO       = 9'd76;
  localparam logic [LINE_W-1:0] EF_TOP_HI       = 9'd79;
  localparam logic [LINE_W-1:0] EF_BOT_LO       = 9'd204;
  localparam logic [LINE_W-1:0] EF_BOT_HI       = 9'd207;

  localparam logic [MC_W-1:0] DMA_MC_LO     = 4'd1;
  localparam logic [MC_W-1:0] DMA_MC_HI     = 4'd8;
  localparam logic [3:0]      BYTES_PER_ROW = 4'd8;

  typedef struct packed {
    logic disp_line;
    logic int_line;
    logic ef_line;
    logic dma_mc;
  } pos_flags_t;

  function automatic logic is_disp_line(input logic [LINE_W-1:0] l);
    return (l >= FIRST_DISP_LINE) && (l <= LAST_DISP_LINE);
  endfunction

  function automatic pos_flags_t decode_pos(input logic [LINE_W-1:0] l,
                                            input logic [MC_W-1:0]   m);
    pos_flags_t f;
    f.disp_line = is_disp_line(l);
    f.int_line  = (l == INT_LINE_0) || (l == INT_LINE_1);
    f.ef_line   = ((l >= EF_TOP_LO) && (l <= EF_TOP_HI)) ||
                  ((l >= EF_BOT_LO) && (l <= EF_BOT_HI));
    f.dma_mc    = (m >= DMA_MC_LO) && (m <= DMA_MC_HI);
    return f;
  endfunction

endpackage

// File: rtl/pixie_dma_ctrl_if.sv
// CPU-side bus and frame-buffer write port of the Pixie front end.
// dma_underrun exists only when PIXIE_DMA_CHECK_EN is defined.
interface pixie_dma_ctrl_if;
  import pixie_pkg::*;

  logic [1:0]        SC;
  logic              disp_on;
  logic              disp_off;
  logic [7:0]        data_in;
  logic              DMAO;
  logic              INT;
  logic              EFx;
  // mem_wr_en is a valid-only strobe: the buffer has no ready, every pulse is one accepted write.
  logic [9:0]        mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wr_en;
`ifdef PIXIE_DMA_CHECK_EN
  logic              dma_underrun;
`endif
  logic [PH_W-1:0]   dbg_ph;
  logic [MC_W-1:0]   dbg_mc;
  logic [LINE_W-1:0] dbg_line;

  modport master (
    output SC, disp_on, disp_off, data_in,
    input  DMAO, INT, EFx, mem_addr, mem_data, mem_wr_en,
`ifdef PIXIE_DMA_CHECK_EN
    input  dma_underrun,
`endif
    input  dbg_ph, dbg_mc, dbg_line
  );

  modport slave (
    input  SC, disp_on, disp_off, data_in,
    output DMAO, INT, EFx, mem_addr, mem_data, mem_wr_en,
`ifdef PIXIE_DMA_CHECK_EN
    output dma_underrun,
`endif
    output dbg_ph, dbg_mc, dbg_line
  );
endinterface

// File: rtl/pixie_timing_gen.sv
// Phase / machine-cycle / scan-line counters of the Pixie, advancing on clk_enable,
// plus decoded flags for the current line and for the position reached at the next phase wrap.
module pixie_timing_gen
  import pixie_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  output logic [PH_W-1:0]   ph,
  output logic [MC_W-1:0]   mc,
  output logic [LINE_W-1:0] line,
  output logic              ph_wrap,
  output logic              last_mc,
  output logic              cur_disp_line,
  output pos_flags_t        nxt_flags
);

  logic [MC_W-1:0]   mc_nxt;
  logic [LINE_W-1:0] line_nxt;

  always_comb begin
    ph_wrap  = clk_enable && (ph == PH_LAST);
    last_mc  = (mc == MC_LAST);
    mc_nxt   = last_mc ? '0 : mc + MC_W'(1);
    line_nxt = line;
    if (last_mc) begin
      line_nxt = (line == LINE_LAST) ? '0 : line + LINE_W'(1);
    end
    cur_disp_line = is_disp_line(line);
    nxt_flags     = decode_pos(line_nxt, mc_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph   <= '0;
      mc   <= '0;
      line <= '0;
    end else if (clk_enable) begin
      ph <= ph_wrap ? '0 : ph + PH_W'(1);
      if (ph_wrap) begin
        mc   <= mc_nxt;
        line <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/pixie_dma_ctrl.sv
// CDP1861 (Pixie) front end: display-enable latch, DMAO/INT/EFx generation and S2 capture
// into the frame-buffer write port. Optional underrun monitor under PIXIE_DMA_CHECK_EN.
module pixie_dma_ctrl
  import pixie_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  pixie_dma_ctrl_if.slave bus
);

  logic [PH_W-1:0]   ph;
  logic [MC_W-1:0]   mc;
  logic [LINE_W-1:0] line;
  logic              ph_wrap;
  logic              last_mc;
  logic              cur_disp_line;
  pos_flags_t        nxt_flags;

  pixie_timing_gen u_timing (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .ph            (ph),
    .mc            (mc),
    .line          (line),
    .ph_wrap       (ph_wrap),
    .last_mc       (last_mc),
    .cur_disp_line (cur_disp_line),
    .nxt_flags     (nxt_flags)
  );

  logic       disp_en;
  logic       disp_en_nxt;
  logic       capture;
  logic [3:0] byte_idx;
  logic [3:0] byte_idx_inc;
  logic [6:0] row;
  logic       dmao_q;
  logic       int_q;
  logic       efx_q;
  logic       wr_en_q;
  logic [9:0] addr_q;
  logic [7:0] data_q;

  always_comb begin
    disp_en_nxt = disp_en;
    if (clk_enable) begin
      if (bus.disp_off) begin
        disp_en_nxt = 1'b0;
      end else if (bus.disp_on) begin
        disp_en_nxt = 1'b1;
      end
    end
    // A row holds 8 bytes; extra S2 cycles in the same line are dropped, never wrapped.
    capture      = ph_wrap && (bus.SC == SC_S2) && disp_en && cur_disp_line &&
                   (byte_idx < BYTES_PER_ROW);
    byte_idx_inc = byte_idx + {3'b000, capture};
    row          = 7'(line - FIRST_DISP_LINE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_en  <= 1'b0;
      byte_idx <= '0;
      dmao_q   <= 1'b0;
      int_q    <= 1'b0;
      efx_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      disp_en <= disp_en_nxt;
      wr_en_q <= capture;
      if (capture) begin
        data_q <= bus.data_in;
        addr_q <= {row, byte_idx[2:0]};
      end
      // Outputs describe the machine cycle being entered, so they use the next position.
      if (ph_wrap) begin
        byte_idx <= last_mc ? '0 : byte_idx_inc;
        dmao_q   <= disp_en_nxt && nxt_flags.disp_line && nxt_flags.dma_mc;
        int_q    <= disp_en_nxt && nxt_flags.int_line;
        efx_q    <= nxt_flags.ef_line;
      end
    end
  end

`ifdef PIXIE_DMA_CHECK_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (clk_enable && bus.disp_on) begin
      underrun_q <= 1'b0;
    end else if (ph_wrap && last_mc && disp_en && cur_disp_line &&
                 (byte_idx_inc < BYTES_PER_ROW)) begin
      underrun_q <= 1'b1;
    end
  end

  assign bus.dma_underrun = underrun_q;
`else
  // Without the monitor the byte count only steers capture and row addressing.
`endif

  assign bus.DMAO      = dmao_q;
  assign bus.INT       = int_q;
  assign bus.EFx       = efx_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.dbg_ph    = ph;
  assign bus.dbg_mc    = mc;
  assign bus.dbg_line  = line;

endmodule
